muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer sitting beside the single-cycle ALU in the execute stage. It handles the funct7=0000001 R-type operations that the combinational ALU does not implement. It accepts one operation at a time from the decoder, stalls the core while a radix-2 (one bit per cycle) shift-add or restoring-divide loop runs, then presents the 32-bit result for write-back.

---
 rtl/muldiv_seq.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
//
// Runs beside the single-cycle ALU in the execute stage. It accepts one
// funct7=0000001 operation at a time and stalls the core while a radix-2 loop
// runs. Multiplies use a shift-add loop and divides use a restoring loop, one
// bit per cycle. It then presents the 32-bit result for one cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     decoder flags an M-extension op (sampled only in IDLE)
//   fn3       RV32M funct3 (mul/mulh/mulhsu/mulhu/div/divu/rem/remu)
//   rs1_data  operand A (multiplicand / dividend)
//   rs2_data  operand B (multiplier / divisor)
//   stall     hold PC and pipeline: (IDLE & start) | CALC
//   done      one-cycle pulse, result valid
//   result    final value, held until the next result is written
//   illegal   one-cycle pulse with done for an op that is not compiled in
//
// Configuration macro: MULDIV_DIV_EN
//   defined   : all eight fn3 codes are supported
//   undefined : divide ops finish in one cycle with illegal=1 and result 0
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      fn3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic [2:0]        op;
    logic              a_neg;
    logic              b_neg;
    logic              illegal_q;

    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] prod;

    logic              a_signed;
    logic              b_signed;
    logic              a_sgn;
    logic              b_sgn;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    logic [2*XLEN-1:0] prod_nxt;
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   mul_res;

    // Signedness per operand: divides use fn3[0] (0 = signed); multiplies
    // treat rs1 as signed except mulhu, and rs2 as signed only for mul/mulh.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (fn3[2]) begin
            a_signed = ~fn3[0];
            b_signed = ~fn3[0];
        end else begin
            a_signed = (fn3[1:0] != 2'b11);
            b_signed = ~fn3[1];
        end
        a_sgn = a_signed & rs1_data[XLEN-1];
        b_sgn = b_signed & rs2_data[XLEN-1];
        a_mag = a_sgn ? -rs1_data : rs1_data;
        b_mag = b_sgn ? -rs2_data : rs2_data;
    end

    // The last iteration's product is used directly so the result can be
    // written on the same edge that leaves CALC.
    always_comb begin
        prod_nxt = mplier[0] ? prod + mcand : prod;
        mul_full = (a_neg ^ b_neg) ? -prod_nxt : prod_nxt;
        mul_res  = (op == 3'b000) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] div_res;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;

    // One restoring step. The partial remainder stays below the divisor, so
    // after a successful subtract it always fits in XLEN bits and the
    // wrap-around subtraction is exact.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        ge      = (shifted >= {1'b0, dvsr});
        rem_nxt = ge ? shifted[XLEN-1:0] - dvsr : shifted[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], ge};
        if (op[1])
            div_res = a_neg ? -rem_nxt : rem_nxt;
        else
            div_res = (a_neg ^ b_neg) ? -quo_nxt : quo_nxt;
    end

    // Divide-by-zero and signed overflow are answered without iterating.
    always_comb begin
        div_zero = (rs2_data == '0);
        div_ovf  = ~fn3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
        special  = fn3[2] & (div_zero | div_ovf);
        if (div_zero)
            spec_res = fn3[1] ? rs1_data : '1;
        else
            spec_res = fn3[1] ? '0 : INT_MIN;
    end
`endif

    // Main sequencer: latch the op in IDLE, iterate 32 times in CALC, then
    // pulse done for one cycle. A start seen in DONE is deliberately dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op        <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            illegal_q <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            result    <= '0;
`ifdef MULDIV_DIV_EN
            quo       <= '0;
            rem       <= '0;
            dvsr      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op        <= fn3;
                        a_neg     <= a_sgn;
                        b_neg     <= b_sgn;
                        cnt       <= '0;
                        mcand     <= {{XLEN{1'b0}}, a_mag};
                        mplier    <= b_mag;
                        prod      <= '0;
                        illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
                        quo       <= a_mag;
                        rem       <= '0;
                        dvsr      <= b_mag;
                        if (special) begin
                            state  <= S_DONE;
                            result <= spec_res;
                        end else begin
                            state  <= S_CALC;
                        end
`else
                        if (fn3[2]) begin
                            state     <= S_DONE;
                            result    <= '0;
                            illegal_q <= 1'b1;
                        end else begin
                            state     <= S_CALC;
                        end
`endif
                    end
                end
                S_CALC: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
`ifdef MULDIV_DIV_EN
                    quo    <= quo_nxt;
                    rem    <= rem_nxt;
`endif
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state  <= S_DONE;
`ifdef MULDIV_DIV_EN
                        result <= op[2] ? div_res : mul_res;
`else
                        result <= mul_res;
`endif
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    illegal_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall   = ((state == S_IDLE) & start) | (state == S_CALC);
    assign done    = (state == S_DONE);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed, table-driven bench for muldiv_seq.
//
// Each table record holds an operation and the expected result, latency,
// stall length and illegal flag; hand-written sequences cover reset values,
// reset in the middle of CALC, and start being ignored in DONE.
// Divide vectors follow the MULDIV_DIV_EN build option.
module tb_muldiv_seq;

    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        logic        ill;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  fn3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .fn3      (fn3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .stall    (stall),
        .done     (done),
        .result   (result),
        .illegal  (illegal)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one op for a single cycle, scramble the inputs afterwards, and
    // wait (bounded) for done while counting stall cycles
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, output int lat,
                                 output int stall_cycles, output logic [31:0] res,
                                 output logic ill);
        lat = 0;
        res = 'x;
        ill = 1'bx;
        @(negedge clk);
        fn3 = f;
        rs1_data = a;
        rs2_data = b;
        start = 1'b1;
        #1;
        stall_cycles = stall ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            fn3 = 3'($urandom_range(7, 0));
            rs1_data = $urandom;
            rs2_data = $urandom;
            #1;
            if (stall) stall_cycles++;
            if (done) begin
                lat = k;
                res = result;
                ill = illegal;
                break;
            end
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e,
                                input int l, input logic il);
        vec_t v;
        v.fn = f; v.a = a; v.b = b; v.exp = e; v.lat = l; v.ill = il;
        return v;
    endfunction

    initial begin
        int lat;
        int sc;
        logic [31:0] res;
        logic ill;

        // multiply vectors (identical in both builds)
        vecs.push_back(mk(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0));
        vecs.push_back(mk(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b0));
        vecs.push_back(mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0));
        vecs.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0));
        vecs.push_back(mk(3'b000, 32'd10,       32'd2,        32'd20,       33, 1'b0));
        vecs.push_back(mk(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0));
        vecs.push_back(mk(3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33, 1'b0));
        vecs.push_back(mk(3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 33, 1'b0));
`ifdef MULDIV_DIV_EN
        vecs.push_back(mk(3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33, 1'b0));
        vecs.push_back(mk(3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33, 1'b0));
        vecs.push_back(mk(3'b101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33, 1'b0));
        vecs.push_back(mk(3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0));
        vecs.push_back(mk(3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        33, 1'b0));
        vecs.push_back(mk(3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, 1'b0));
        vecs.push_back(mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 1'b0));
        vecs.push_back(mk(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0));
        vecs.push_back(mk(3'b111, 32'd5,        32'd0,        32'd5,        1,  1'b0));
        vecs.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0));
        vecs.push_back(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b0));
`else
        vecs.push_back(mk(3'b100, 32'd10,       32'd2,        32'h00000000, 1,  1'b1));
        vecs.push_back(mk(3'b111, 32'd5,        32'd0,        32'h00000000, 1,  1'b1));
`endif

        // reset values, stall following start while in reset
        rst = 1'b1;
        start = 1'b0;
        fn3 = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        #1;
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset done", {31'b0, done}, 32'h0);
        checkOutput("reset illegal", {31'b0, illegal}, 32'h0);
        checkOutput("reset stall start0", {31'b0, stall}, 32'h0);
        start = 1'b1;
        #1;
        checkOutput("reset stall start1", {31'b0, stall}, 32'h1);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // table-driven vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].fn, vecs[i].a, vecs[i].b, lat, sc, res, ill);
            checkOutput($sformatf("vec%0d result", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d stall cycles", i), 32'(sc), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d illegal", i), {31'b0, ill}, {31'b0, vecs[i].ill});
            @(negedge clk);
            #1;
            checkOutput($sformatf("vec%0d done pulse", i), {31'b0, done}, 32'h0);
            checkOutput($sformatf("vec%0d illegal pulse", i), {31'b0, illegal}, 32'h0);
            checkOutput($sformatf("vec%0d result held", i), result, vecs[i].exp);
        end

        // reset in the middle of a multiply, start held high
        @(negedge clk);
        fn3 = 3'b000;
        rs1_data = 32'd5;
        rs2_data = 32'd6;
        start = 1'b1;
        repeat (11) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midcalc rst result", result, 32'h0);
        checkOutput("midcalc rst done", {31'b0, done}, 32'h0);
        checkOutput("midcalc rst illegal", {31'b0, illegal}, 32'h0);
        checkOutput("midcalc rst stall start1", {31'b0, stall}, 32'h1);
        start = 1'b0;
        #1;
        checkOutput("midcalc rst stall start0", {31'b0, stall}, 32'h0);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fn3 = 3'b000;
        rs1_data = 32'd9;
        rs2_data = 32'd7;

        // new multiply with start and operands toggling while it runs
        lat = 0;
        res = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k % 2 == 1);
            fn3 = 3'($urandom_range(7, 0));
            rs1_data = $urandom;
            rs2_data = $urandom;
            #1;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
        checkOutput("post-reset mul latency", 32'(lat), 32'd33);
        checkOutput("post-reset mul result", res, 32'd63);
        checkOutput("start in done stall", {31'b0, start & ~stall}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("start in done ignored", {31'b0, stall}, 32'h0);
        checkOutput("after done pulse", {31'b0, done}, 32'h0);
        checkOutput("after done result held", result, 32'd63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
